// File: rtl/mem_dma_master.sv
// mem_dma_master: bus initiator on the CPU memory bus.
// Runs block FILL, COPY and VERIFY operations over the word address space,
// so memory init, self-test and IO pokes need no CPU involvement.
// Reads take two cycles because the RAM read port is registered. MREAD is
// held on the same address through RD0 and RD1, and read_data is taken at
// the end of RD1. Each write is a single MWRITE cycle.
module mem_dma_master #(
  parameter int DW = 16,
  parameter int AW = 9,
  parameter int LW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] pattern,
  input  logic          incr,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] write_data,
  input  logic [DW-1:0] read_data,
  output logic          busy,
  output logic          done,
  output logic          illegal,
  output logic [LW-1:0] err_count,
  output logic [AW-1:0] first_err_addr
);

  localparam logic [1:0] MODE_FILL    = 2'b00;
  localparam logic [1:0] MODE_COPY    = 2'b01;
  localparam logic [1:0] MODE_VERIFY  = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_next;

  logic [1:0]    mode_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [LW-1:0] len_q;
  logic [DW-1:0] pattern_q;
  logic          incr_q;

  logic [LW-1:0] idx;
  logic [LW-1:0] idx_next;

  logic          accept;
  logic          launch_active;
  logic          is_fill;
  logic          is_copy;
  logic          is_verify;
  logic          last_word;
  logic          word_end;
  logic          mismatch;

  logic [DW-1:0] cur_data;
  logic [DW-1:0] next_data;
  logic [AW-1:0] dst_cur;
  logic [AW-1:0] dst_next;
  logic [AW-1:0] src_next;

  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] write_data_q;
  logic          illegal_q;
  logic [LW-1:0] err_count_q;
  logic [AW-1:0] first_err_q;

  // Request decode. An accepted start with len=0 or the illegal mode goes
  // straight to DONE and never touches the bus.
  assign accept        = (state == S_IDLE) && start;
  assign launch_active = accept && (mode != MODE_ILLEGAL) && (len != '0);

  assign is_fill   = (mode_q == MODE_FILL);
  assign is_copy   = (mode_q == MODE_COPY);
  assign is_verify = (mode_q == MODE_VERIFY);

  // A word is finished after its WR cycle, or after RD1 when verifying.
  // len_q is never zero while these states are active.
  assign last_word = (idx == len_q - LW'(1));
  assign word_end  = (state == S_WR) || ((state == S_RD1) && is_verify);
  assign idx_next  = idx + LW'(1);

  // Expected or written data for the current word and the next word.
  // Both wrap modulo 2^DW when incrementing.
  assign cur_data  = pattern_q + (incr_q ? DW'(idx) : '0);
  assign next_data = pattern_q + (incr_q ? DW'(idx_next) : '0);

  // Addresses wrap modulo 2^AW, so a run can cross from the top of the map
  // back to zero, or from RAM into I/O space.
  assign dst_cur  = dst_q + AW'(idx);
  assign dst_next = dst_q + AW'(idx_next);
  assign src_next = src_q + AW'(idx_next);

  assign mismatch = (state == S_RD1) && is_verify && (read_data != cur_data);

  // Next-state selection for the transfer sequencer.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!launch_active) begin
            state_next = S_DONE;
          end else if (mode == MODE_FILL) begin
            state_next = S_WR;
          end else begin
            state_next = S_RD0;
          end
        end
      end
      S_RD0: begin
        state_next = S_RD1;
      end
      S_RD1: begin
        if (is_copy) begin
          state_next = S_WR;
        end else if (last_word) begin
          state_next = S_DONE;
        end else begin
          state_next = S_RD0;
        end
      end
      S_WR: begin
        if (last_word) begin
          state_next = S_DONE;
        end else if (is_fill) begin
          state_next = S_WR;
        end else begin
          state_next = S_RD0;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register. Reset aborts any operation in progress immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture operands on acceptance so input changes while busy are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MODE_FILL;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      pattern_q <= '0;
      incr_q    <= 1'b0;
    end else if (accept) begin
      mode_q    <= mode;
      src_q     <= src_addr;
      dst_q     <= dst_addr;
      len_q     <= len;
      pattern_q <= pattern;
      incr_q    <= incr;
    end
  end

  // Word index, advanced at the end of every word except the last.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (accept) begin
      idx <= '0;
    end else if (word_end && !last_word) begin
      idx <= idx_next;
    end
  end

  // Bus address register, loaded for the cycle that is about to start.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q <= '0;
    end else if (launch_active) begin
      mem_addr_q <= (mode == MODE_COPY) ? src_addr : dst_addr;
    end else if ((state == S_RD1) && is_copy) begin
      mem_addr_q <= dst_cur;
    end else if (word_end && !last_word) begin
      mem_addr_q <= is_copy ? src_next : dst_next;
    end
  end

  // Write data register. It holds its value outside WR. A copy forwards the
  // word read during RD1 straight into the following write.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_data_q <= '0;
    end else if (launch_active && (mode == MODE_FILL)) begin
      write_data_q <= pattern;
    end else if ((state == S_RD1) && is_copy) begin
      write_data_q <= read_data;
    end else if ((state == S_WR) && is_fill && !last_word) begin
      write_data_q <= next_data;
    end
  end

  // Verify results: a saturating mismatch count and the first failing
  // address. Both clear on acceptance and hold after completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= '0;
      first_err_q <= '0;
    end else if (accept) begin
      err_count_q <= '0;
      first_err_q <= '0;
    end else if (mismatch) begin
      if (err_count_q == '0) begin
        first_err_q <= mem_addr_q;
      end
      if (err_count_q != '1) begin
        err_count_q <= err_count_q + LW'(1);
      end
    end
  end

  // Sticky illegal-mode flag. It is reevaluated on every accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (accept) begin
      illegal_q <= (mode == MODE_ILLEGAL);
    end
  end

  // The bus command is a pure function of state. Reads hold MREAD through
  // both RD0 and RD1.
  always_comb begin
    mem_cmd = CMD_NONE;
    case (state)
      S_RD0:   mem_cmd = CMD_READ;
      S_RD1:   mem_cmd = CMD_READ;
      S_WR:    mem_cmd = CMD_WRITE;
      default: mem_cmd = CMD_NONE;
    endcase
  end

  assign mem_addr       = mem_addr_q;
  assign write_data     = write_data_q;
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign illegal        = illegal_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_mem_dma_master.sv
// tb_mem_dma_master: directed scenarios for mem_dma_master.
// A small bus responder stands in for the RAM and the LED port. It has a
// registered read, RAM at bit 8 = 0 and LEDs at bit 8 = 1.
module tb_mem_dma_master;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] len;
  logic [DW-1:0] pattern;
  logic          incr;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          busy;
  logic          done;
  logic          illegal;
  logic [LW-1:0] err_count;
  logic [AW-1:0] first_err_addr;

  logic [DW-1:0] ram [256] = '{default: '0};
  logic [7:0]    ledr = 8'h00;
  int            bus_writes = 0;
  int            bus_reads = 0;

  int checks = 0;
  int passes = 0;

  mem_dma_master #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mode           (mode),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .len            (len),
    .pattern        (pattern),
    .incr           (incr),
    .mem_cmd        (mem_cmd),
    .mem_addr       (mem_addr),
    .write_data     (write_data),
    .read_data      (read_data),
    .busy           (busy),
    .done           (done),
    .illegal        (illegal),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  // Bus responder with a registered read, RAM storage and an LED register.
  always @(posedge clk) begin
    if (mem_cmd == 2'b10) begin
      bus_writes <= bus_writes + 1;
      if (!mem_addr[8]) ram[mem_addr[7:0]] <= write_data;
      else ledr <= write_data[7:0];
    end
    if (mem_cmd == 2'b01) bus_reads <= bus_reads + 1;
    read_data <= mem_addr[8] ? {8'h00, ledr} : ram[mem_addr[7:0]];
  end

  // Safety net in case the run stalls for any reason.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [LW-1:0] l, input logic [DW-1:0] p, input logic i);
    mode = m; src_addr = s; dst_addr = d; len = l; pattern = p; incr = i;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({mem_cmd, mem_addr, write_data, busy, done, illegal, err_count, first_err_addr} !== '0)
      $display("[TB] FAIL reset_state: got cmd=%b addr=%h data=%h busy=%b done=%b ill=%b err=%0d first=%h, want all zero",
               mem_cmd, mem_addr, write_data, busy, done, illegal, err_count, first_err_addr);
    else passes++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    launch(2'b00, 9'h000, 9'h010, 9'd4, 16'hA500, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busy, mem_cmd, mem_addr, write_data} !== {1'b1, 2'b10, 9'h010 + 9'(i), 16'hA500 + 16'(i)})
        $display("[TB] FAIL fill_word%0d: got busy=%b cmd=%b addr=%h data=%h, want busy=1 cmd=10 addr=%h data=%h",
                 i, busy, mem_cmd, mem_addr, write_data, 9'h010 + 9'(i), 16'hA500 + 16'(i));
      else passes++;
      tick();
    end
    checks++;
    if ({done, busy, mem_cmd} !== {1'b1, 1'b1, 2'b00})
      $display("[TB] FAIL fill_done: got done=%b busy=%b cmd=%b, want 1 1 00", done, busy, mem_cmd);
    else passes++;
    tick();
    checks++;
    if ({done, busy} !== 2'b00)
      $display("[TB] FAIL fill_idle: got done=%b busy=%b, want 0 0", done, busy);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram[8'h10 + 8'(i)] !== 16'hA500 + 16'(i))
        $display("[TB] FAIL fill_ram%0d: got %h, want %h", i, ram[8'h10 + 8'(i)], 16'hA500 + 16'(i));
      else passes++;
    end
  endtask

  task automatic test_copy();
    int dones = 0;
    launch(2'b01, 9'h010, 9'h040, 9'd3, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        checks++;
        if ({mem_cmd, mem_addr} !== {2'b01, 9'h010 + 9'(i)})
          $display("[TB] FAIL copy_read%0d_%0d: got cmd=%b addr=%h, want cmd=01 addr=%h",
                   i, ph, mem_cmd, mem_addr, 9'h010 + 9'(i));
        else passes++;
        dones += int'(done);
        tick();
      end
      checks++;
      if ({mem_cmd, mem_addr, write_data} !== {2'b10, 9'h040 + 9'(i), 16'hA500 + 16'(i)})
        $display("[TB] FAIL copy_write%0d: got cmd=%b addr=%h data=%h, want cmd=10 addr=%h data=%h",
                 i, mem_cmd, mem_addr, write_data, 9'h040 + 9'(i), 16'hA500 + 16'(i));
      else passes++;
      dones += int'(done);
      tick();
    end
    checks++;
    if ({done, mem_cmd} !== {1'b1, 2'b00})
      $display("[TB] FAIL copy_done: got done=%b cmd=%b, want 1 00", done, mem_cmd);
    else passes++;
    for (int k = 0; k < 3; k++) begin
      dones += int'(done);
      tick();
    end
    checks++;
    if (dones !== 1)
      $display("[TB] FAIL copy_done_count: got %0d done pulses, want 1", dones);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ram[8'h40 + 8'(i)] !== 16'hA500 + 16'(i))
        $display("[TB] FAIL copy_ram%0d: got %h, want %h", i, ram[8'h40 + 8'(i)], 16'hA500 + 16'(i));
      else passes++;
    end
  endtask

  task automatic test_verify();
    // Corrupt word 0x12 through the DUT itself.
    launch(2'b00, 9'h000, 9'h012, 9'd1, 16'h0000, 1'b0);
    tick();
    tick();
    launch(2'b10, 9'h000, 9'h010, 9'd4, 16'hA500, 1'b1);
    checks++;
    if ({mem_cmd, mem_addr} !== {2'b01, 9'h010})
      $display("[TB] FAIL verify_first_read: got cmd=%b addr=%h, want 01 010", mem_cmd, mem_addr);
    else passes++;
    repeat (8) tick();
    checks++;
    if ({done, err_count, first_err_addr} !== {1'b1, 9'd1, 9'h012})
      $display("[TB] FAIL verify_corrupt: got done=%b err=%0d first=%h, want done=1 err=1 first=012",
               done, err_count, first_err_addr);
    else passes++;
    tick();
    checks++;
    if ({busy, err_count, first_err_addr} !== {1'b0, 9'd1, 9'h012})
      $display("[TB] FAIL verify_hold: got busy=%b err=%0d first=%h, want busy=0 err=1 first=012",
               busy, err_count, first_err_addr);
    else passes++;
    // Repair the word and verify again.
    launch(2'b00, 9'h000, 9'h012, 9'd1, 16'hA502, 1'b0);
    tick();
    tick();
    launch(2'b10, 9'h000, 9'h010, 9'd4, 16'hA500, 1'b1);
    repeat (8) tick();
    checks++;
    if ({done, err_count, first_err_addr} !== {1'b1, 9'd0, 9'h000})
      $display("[TB] FAIL verify_clean: got done=%b err=%0d first=%h, want done=1 err=0 first=000",
               done, err_count, first_err_addr);
    else passes++;
    tick();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_addr [3] = '{9'h1FE, 9'h1FF, 9'h000};
    launch(2'b00, 9'h000, 9'h1FE, 9'd3, 16'h00FF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_cmd, mem_addr, write_data} !== {2'b10, exp_addr[i], 16'h00FF})
        $display("[TB] FAIL wrap_word%0d: got cmd=%b addr=%h data=%h, want cmd=10 addr=%h data=00ff",
                 i, mem_cmd, mem_addr, write_data, exp_addr[i]);
      else passes++;
      tick();
    end
    checks++;
    if (done !== 1'b1)
      $display("[TB] FAIL wrap_done: got done=%b, want 1", done);
    else passes++;
    tick();
    checks++;
    if (ram[0] !== 16'h00FF)
      $display("[TB] FAIL wrap_ram0: got %h, want 00ff", ram[0]);
    else passes++;
  endtask

  task automatic test_led();
    logic [DW-1:0] snap [256];
    int diffs = 0;
    for (int i = 0; i < 256; i++) snap[i] = ram[i];
    launch(2'b00, 9'h000, 9'h100, 9'd1, 16'h005A, 1'b0);
    checks++;
    if ({mem_cmd, mem_addr, write_data} !== {2'b10, 9'h100, 16'h005A})
      $display("[TB] FAIL led_write: got cmd=%b addr=%h data=%h, want 10 100 005a", mem_cmd, mem_addr, write_data);
    else passes++;
    tick();
    tick();
    checks++;
    if (ledr !== 8'h5A)
      $display("[TB] FAIL led_value: got %h, want 5a", ledr);
    else passes++;
    for (int i = 0; i < 256; i++) if (ram[i] !== snap[i]) diffs++;
    checks++;
    if (diffs !== 0)
      $display("[TB] FAIL led_ram_untouched: got %0d changed words, want 0", diffs);
    else passes++;
  endtask

  task automatic test_len_zero();
    int activity = bus_writes + bus_reads;
    launch(2'b00, 9'h000, 9'h020, 9'd0, 16'h1234, 1'b1);
    checks++;
    if ({done, busy, mem_cmd} !== {1'b1, 1'b1, 2'b00})
      $display("[TB] FAIL len0_done: got done=%b busy=%b cmd=%b, want 1 1 00", done, busy, mem_cmd);
    else passes++;
    tick();
    checks++;
    if ({done, busy} !== 2'b00)
      $display("[TB] FAIL len0_idle: got done=%b busy=%b, want 0 0", done, busy);
    else passes++;
    checks++;
    if ((bus_writes + bus_reads) !== activity)
      $display("[TB] FAIL len0_bus: got %0d bus commands, want %0d", bus_writes + bus_reads, activity);
    else passes++;
  endtask

  task automatic test_illegal();
    int activity = bus_writes + bus_reads;
    launch(2'b11, 9'h010, 9'h030, 9'd5, 16'hFFFF, 1'b1);
    checks++;
    if ({done, illegal, mem_cmd} !== {1'b1, 1'b1, 2'b00})
      $display("[TB] FAIL illegal_done: got done=%b illegal=%b cmd=%b, want 1 1 00", done, illegal, mem_cmd);
    else passes++;
    repeat (3) tick();
    checks++;
    if ({busy, illegal} !== 2'b01)
      $display("[TB] FAIL illegal_sticky: got busy=%b illegal=%b, want 0 1", busy, illegal);
    else passes++;
    checks++;
    if ((bus_writes + bus_reads) !== activity)
      $display("[TB] FAIL illegal_bus: got %0d bus commands, want %0d", bus_writes + bus_reads, activity);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int writes_at_reset;
    launch(2'b01, 9'h010, 9'h050, 9'd3, 16'h0000, 1'b0);
    checks++;
    if (illegal !== 1'b0)
      $display("[TB] FAIL illegal_cleared: got %b, want 0", illegal);
    else passes++;
    tick();
    tick();
    checks++;
    if ({mem_cmd, mem_addr} !== {2'b10, 9'h050})
      $display("[TB] FAIL midreset_write0: got cmd=%b addr=%h, want 10 050", mem_cmd, mem_addr);
    else passes++;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({mem_cmd, busy, done, mem_addr} !== {2'b00, 1'b0, 1'b0, 9'h000})
      $display("[TB] FAIL midreset_abort: got cmd=%b busy=%b done=%b addr=%h, want 00 0 0 000",
               mem_cmd, busy, done, mem_addr);
    else passes++;
    reset = 1'b0;
    writes_at_reset = bus_writes;
    repeat (10) tick();
    checks++;
    if (bus_writes !== writes_at_reset)
      $display("[TB] FAIL midreset_no_writes: got %0d writes, want %0d", bus_writes, writes_at_reset);
    else passes++;
    checks++;
    if ({ram[8'h50], ram[8'h51]} !== {16'hA500, 16'h0000})
      $display("[TB] FAIL midreset_ram: got %h %h, want a500 0000", ram[8'h50], ram[8'h51]);
    else passes++;
  endtask

  task automatic test_back_to_back();
    launch(2'b00, 9'h000, 9'h060, 9'd3, 16'h1230, 1'b1);
    mode = 2'b10; dst_addr = 9'h070; len = 9'd5; pattern = 16'hFFFF; incr = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({mem_cmd, mem_addr, write_data} !== {2'b10, 9'h061, 16'h1231})
      $display("[TB] FAIL b2b_word1: got cmd=%b addr=%h data=%h, want 10 061 1231", mem_cmd, mem_addr, write_data);
    else passes++;
    tick();
    checks++;
    if ({mem_cmd, mem_addr, write_data} !== {2'b10, 9'h062, 16'h1232})
      $display("[TB] FAIL b2b_word2: got cmd=%b addr=%h data=%h, want 10 062 1232", mem_cmd, mem_addr, write_data);
    else passes++;
    tick();
    checks++;
    if (done !== 1'b1)
      $display("[TB] FAIL b2b_done: got done=%b, want 1", done);
    else passes++;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if ({busy, mem_cmd} !== {1'b0, 2'b00})
      $display("[TB] FAIL b2b_no_restart: got busy=%b cmd=%b, want 0 00", busy, mem_cmd);
    else passes++;
    checks++;
    if ({ram[8'h60], ram[8'h61], ram[8'h62], ram[8'h70]} !== {16'h1230, 16'h1231, 16'h1232, 16'h0000})
      $display("[TB] FAIL b2b_ram: got %h %h %h %h, want 1230 1231 1232 0000",
               ram[8'h60], ram[8'h61], ram[8'h62], ram[8'h70]);
    else passes++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; src_addr = '0; dst_addr = '0;
    len = '0; pattern = '0; incr = 1'b0;
    $display("[TB] starting mem_dma_master directed tests");
    test_reset();
    test_fill();
    test_copy();
    test_verify();
    test_wrap();
    test_led();
    test_len_zero();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
